// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, imem request/ready handshake, IR.
// Define MISALIGN_CHECK_EN to trap misaligned jump/branch targets.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] tgt;

  logic sel_seq, sel_br, sel_jalr, sel_jal;

  assign sel_seq  = (pcsource == 2'b00);
  assign sel_br   = (pcsource == 2'b01);
  assign sel_jalr = (pcsource == 2'b10);
  assign sel_jal  = (pcsource == 2'b11);

  always_comb begin
    tgt = pc_q + 32'd4;
    unique case (1'b1)
      sel_seq:  tgt = pc_q + 32'd4;
      sel_br:   tgt = pc_q + imm;
      sel_jalr: tgt = (rs1_data + imm) & ~32'h1;
      sel_jal:  tgt = pc_q + imm;
      default:  tgt = pc_q + 32'd4;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  logic fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    req_d   = req_q;
    addr_d  = addr_q;
`ifdef MISALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = {pc_q[31:2], 2'b00};
        end else if (imem_ready) begin
          inst_d  = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_d    = tgt;
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          state_d = FETCH;
`ifdef MISALIGN_CHECK_EN
          if (tgt[1:0] != 2'b00) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
`endif
        end
      end
`ifdef MISALIGN_CHECK_EN
      FAULT: begin
        req_d = 1'b0;
      end
`endif
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC & ~32'h3;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) fault_q <= 1'b0;
    else         fault_q <= fault_d;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;

endmodule
